fsm_watch_monitor: RTL and testbench
====================================

// Module: fsm_watch_monitor
// PURPOSE
//  Synthesizable, parametrised FSM health monitor. Watches N_CH FSM state buses in parallel.
//  Per channel it flags illegal transitions (checked against a legal-transition map) and
//  lock-up, meaning the FSM dwells in one non-exempt state longer than TIMEOUT cycles.
//  Errors are reported once each, through a serialised report port and sticky flags.
//  It sits beside the control FSMs under test and stays live in silicon, unlike bench-only assertions.
// PARAMETERS
//  N_CH       4                          number of monitored FSM channels
//  STATE_W    4                          width of each state bus; NS = 2**STATE_W
//  TIMEOUT    16                         max consecutive cycles in one state (>=2)
//  IDLE_STATE 0                          state exempt from timeout (may dwell forever)
//  LEGAL_MAP  '1 (NS*NS bits)            bit[from*NS+to]=1 -> from->to legal; self-loops always legal
//  ERR_CNT_W  8                          width of saturating error counter
// PORTS
//  clk         in   1              sample clock
//  rst_n       in   1              async active-low reset
//  enable_i    in   1              monitoring enable
//  clear_i     in   1              sync pulse: clear sticky flags, pending reports, error count
//  state_i     in   N_CH*STATE_W   channel c state at [c*STATE_W +: STATE_W]
//  timeout_o   out  N_CH           sticky per-channel lock-up flag
//  illegal_o   out  N_CH           sticky per-channel illegal-transition flag
//  err_valid_o out  1              one-cycle pulse: one error report presented
//  err_ch_o    out  $clog2(N_CH)   channel of the reported error (0 when !err_valid_o)
//  err_code_o  out  2              err_code_e of the report (ERR_NONE when !err_valid_o)
//  err_cnt_o   out  ERR_CNT_W      total errors detected, saturating at all-ones
// BEHAVIOUR
//  Reset: every output is 0. All channels are DISARMED; prev/dwell registers are 0.
//  Per-channel FSM:
//   DISARMED -> ARM when enable_i=1.
//   ARM: capture state_i into prev_q, set dwell_q=0, no checks -> WATCH.
//   WATCH, with new state s, previous state p:
//    s!=p and LEGAL_MAP[p*NS+s]=0 -> illegal event.
//    s!=p -> dwell_q=0.
//    s==p -> dwell_q increments, saturating at TIMEOUT.
//    Timeout event fires once, on the sample where dwell_q reaches TIMEOUT-1 -> TIMEOUT
//    with p!=IDLE_STATE, i.e. on the (TIMEOUT+1)th consecutive sample of p.
//    A new timeout requires a state change first.
//    prev_q<=s every cycle.
//   Any state, enable_i=0 -> DISARMED; flags and pending reports are retained.
//  Events: the detecting sample sets the sticky flag, the pending bit and the pending code
//   at the next edge. Illegal and timeout in the same cycle on the same channel give code ERR_BOTH.
//   err_cnt_o adds 1 per channel per event-cycle, so up to N_CH per cycle, saturating.
//  Reporting: fixed priority, lowest channel with pending set, one report per cycle.
//   err_valid_o/err_ch_o/err_code_o are registered: one cycle after the pending bit is visible.
//   The reported channel's pending bit is cleared in the same cycle the report is issued.
//   A new event on a channel that is still pending ORs into its pending code; it is not lost.
//  clear_i: zeroes flags, pending bits and err_cnt_o.
//   An event detected in the same cycle as clear_i still sets its flag and pending bit and counts 1.
//   The report in flight that cycle is still output.
//  Async reset mid-operation: immediate return to reset values; pending reports are dropped.
//  Latency: state_i sample -> flag = 1 cycle; -> err_valid_o >= 2 cycles.
// STRUCTURE
//  fsm_mon_pkg holds:
//   typedef enum logic[1:0] err_code_e {ERR_NONE=0, ERR_TIMEOUT=1, ERR_ILLEGAL=2, ERR_BOTH=3}
//   typedef enum logic[1:0] chan_st_e {DISARMED, ARM, WATCH}
//   function legal(map, from, to)
//  Sub-module fsm_mon_channel: per-channel FSM, prev/dwell registers, event detect.
//   Instantiated N_CH times via generate.
//  Top level: pending/priority report logic, saturating counter, clear handling.
// TESTING (N_CH=4, STATE_W=4, TIMEOUT=16, LEGAL_MAP allows only 0->1->2->3->0 and self-loops)
//  Ch0 cycles 0,1,2,3,0 each held 3 cycles -> no flags, err_valid_o never set, err_cnt_o=0.
//  Ch1 jumps 1->3 -> illegal_o[1]=1 next edge; next cycle err_valid_o=1, err_ch_o=1,
//   err_code_o=ERR_ILLEGAL, err_cnt_o=1.
//  Ch2 held at 2 for 17 samples -> timeout_o[2] rises on the 17th; exactly one report, ERR_TIMEOUT.
//   Ch2 held at 0 for 100 samples -> no timeout.
//  Ch0 and ch3 make illegal jumps in the same cycle -> err_cnt_o+=2.
//   Reports on consecutive cycles: ch0 first, then ch3.
//  Ch1 illegal event in the same cycle as clear_i -> illegal_o[1]=1 and err_cnt_o=1 afterwards.
//  rst_n low while reports are pending -> all outputs 0; no report after release.
//   enable_i=0 then 1 -> ARM cycle; a 3->1 jump during re-arm is not flagged.

Source files
------------

// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared types and legal-transition lookup for the FSM watch monitor
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ILLEGAL = 2'd2,
        ERR_BOTH    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARM      = 2'd1,
        WATCH    = 2'd2
    } chan_st_e;

    // Maps are zero-extended to this size so one lookup serves any STATE_W up to MAX_SW.
    localparam int MAX_SW    = 6;
    localparam int MAP_IDX_W = 2 * MAX_SW;
    localparam int MAP_MAX   = 1 << MAP_IDX_W;

    function automatic logic legal(input logic [MAP_MAX-1:0] map,
                                   input logic [MAX_SW-1:0]  from,
                                   input logic [MAX_SW-1:0]  to,
                                   input int unsigned        state_w);
        logic [MAP_IDX_W-1:0] idx;
        idx = (MAP_IDX_W'(from) << state_w) | MAP_IDX_W'(to);
        return (from == to) || map[idx];
    endfunction

endpackage

// File: rtl/fsm_mon_channel.sv
// rtl/fsm_mon_channel.sv - one monitored FSM: arm/watch control, dwell tracking, event detect
module fsm_mon_channel
    import fsm_mon_pkg::*;
#(
    parameter int STATE_W    = 4,
    parameter int TIMEOUT    = 16,
    parameter int IDLE_STATE = 0,
    parameter logic [(2**STATE_W)*(2**STATE_W)-1:0] LEGAL_MAP = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [STATE_W-1:0] state_i,
    output logic               timeout_evt_o,
    output logic               illegal_evt_o
);

    localparam int DW = $clog2(TIMEOUT + 1);
    localparam logic [MAP_MAX-1:0] MAP_EXT = MAP_MAX'(LEGAL_MAP);
    localparam logic [DW-1:0] TO_MAX = DW'(TIMEOUT);
    localparam logic [DW-1:0] TO_PRE = DW'(TIMEOUT - 1);
    localparam logic [STATE_W-1:0] IDLE = STATE_W'(IDLE_STATE);

    chan_st_e           state_q, state_d;
    logic [STATE_W-1:0] prev_q, prev_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic               changed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DISARMED;
            prev_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: state_d = ARM;
                ARM:      state_d = WATCH;
                WATCH:    state_d = WATCH;
                default:  state_d = DISARMED;
            endcase
        end
    end

    // Dwell saturates at TIMEOUT so the lock-up event fires once per stay in a state.
    always_comb begin
        prev_d        = prev_q;
        dwell_d       = dwell_q;
        timeout_evt_o = 1'b0;
        illegal_evt_o = 1'b0;
        changed       = (state_i != prev_q);
        if (enable_i) begin
            case (state_q)
                ARM: begin
                    prev_d  = state_i;
                    dwell_d = '0;
                end
                WATCH: begin
                    prev_d = state_i;
                    if (changed) begin
                        dwell_d       = '0;
                        illegal_evt_o = !legal(MAP_EXT, MAX_SW'(prev_q), MAX_SW'(state_i), STATE_W);
                    end else if (dwell_q != TO_MAX) begin
                        dwell_d       = dwell_q + DW'(1);
                        timeout_evt_o = (dwell_q == TO_PRE) && (prev_q != IDLE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fsm_watch_monitor.sv
// rtl/fsm_watch_monitor.sv - multi-channel FSM health monitor with serialised error reports
module fsm_watch_monitor
    import fsm_mon_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STATE_W    = 4,
    parameter int TIMEOUT    = 16,
    parameter int IDLE_STATE = 0,
    parameter logic [(2**STATE_W)*(2**STATE_W)-1:0] LEGAL_MAP = '1,
    parameter int ERR_CNT_W  = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [N_CH*STATE_W-1:0]   state_i,
    output logic [N_CH-1:0]           timeout_o,
    output logic [N_CH-1:0]           illegal_o,
    output logic                      err_valid_o,
    output logic [CH_W-1:0]           err_ch_o,
    output logic [1:0]                err_code_o,
    output logic [ERR_CNT_W-1:0]      err_cnt_o
);

    localparam int SUM_W = ERR_CNT_W + $clog2(N_CH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_W{1'b1}});

    logic [N_CH-1:0]       evt_to, evt_ill, evt_any;
    logic [N_CH-1:0][1:0]  evt_code;

    logic [N_CH-1:0]       timeout_q, timeout_d;
    logic [N_CH-1:0]       illegal_q, illegal_d;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [N_CH-1:0][1:0]  code_q, code_d;
    logic                  valid_q, valid_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    err_code_e             rcode_q, rcode_d;
    logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;

    logic                  found;
    logic [CH_W-1:0]       sel;
    logic [SUM_W-1:0]      sum;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        fsm_mon_channel #(
            .STATE_W    (STATE_W),
            .TIMEOUT    (TIMEOUT),
            .IDLE_STATE (IDLE_STATE),
            .LEGAL_MAP  (LEGAL_MAP)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable_i      (enable_i),
            .state_i       (state_i[c*STATE_W +: STATE_W]),
            .timeout_evt_o (evt_to[c]),
            .illegal_evt_o (evt_ill[c])
        );
        assign evt_code[c] = {evt_ill[c], evt_to[c]};
    end

    assign evt_any = evt_to | evt_ill;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pend_q[c]) begin
                found = 1'b1;
                sel   = CH_W'(c);
            end
        end
    end

    // The selected report drains its pending bit; a same-cycle event starts a fresh code.
    always_comb begin
        pend_d = '0;
        code_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (pend_q[c] && !clear_i && !(found && sel == CH_W'(c))) begin
                pend_d[c] = 1'b1;
                code_d[c] = code_q[c] | evt_code[c];
            end else begin
                pend_d[c] = evt_any[c];
                code_d[c] = evt_code[c];
            end
        end
        timeout_d = (clear_i ? '0 : timeout_q) | evt_to;
        illegal_d = (clear_i ? '0 : illegal_q) | evt_ill;
        sum = clear_i ? '0 : SUM_W'(cnt_q);
        for (int c = 0; c < N_CH; c++) begin
            sum = sum + SUM_W'(evt_any[c]);
        end
        cnt_d   = (sum > CNT_MAX) ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
        valid_d = found;
        ch_d    = found ? sel : '0;
        rcode_d = found ? err_code_e'(code_q[sel]) : ERR_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= '0;
            illegal_q <= '0;
            pend_q    <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            rcode_q   <= ERR_NONE;
            cnt_q     <= '0;
        end else begin
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
            pend_q    <= pend_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ch_q      <= ch_d;
            rcode_q   <= rcode_d;
            cnt_q     <= cnt_d;
        end
    end

    assign timeout_o   = timeout_q;
    assign illegal_o   = illegal_q;
    assign err_valid_o = valid_q;
    assign err_ch_o    = ch_q;
    assign err_code_o  = rcode_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fsm_watch_monitor.sv
// tb/tb_fsm_watch_monitor.sv - directed scoreboard bench for fsm_watch_monitor
module tb_fsm_watch_monitor;
    import fsm_mon_pkg::*;

    localparam logic [255:0] MAP = (256'd1 << 1) | (256'd1 << 18) | (256'd1 << 35) | (256'd1 << 48);

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] code;
    } rep_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic        clear_i;
    logic [3:0]  st [4];
    logic [15:0] state_i;
    logic [3:0]  timeout_o;
    logic [3:0]  illegal_o;
    logic        err_valid_o;
    logic [1:0]  err_ch_o;
    logic [1:0]  err_code_o;
    logic [7:0]  err_cnt_o;

    rep_t exp_q[$];
    rep_t e;
    int   checks = 0;
    int   errors = 0;
    int   seq[5] = '{0, 1, 2, 3, 0};

    assign state_i = {st[3], st[2], st[1], st[0]};

    always #5 clk = ~clk;

    fsm_watch_monitor #(
        .N_CH       (4),
        .STATE_W    (4),
        .TIMEOUT    (16),
        .IDLE_STATE (0),
        .LEGAL_MAP  (MAP),
        .ERR_CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .state_i     (state_i),
        .timeout_o   (timeout_o),
        .illegal_o   (illegal_o),
        .err_valid_o (err_valid_o),
        .err_ch_o    (err_ch_o),
        .err_code_o  (err_code_o),
        .err_cnt_o   (err_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_timeout"}, 32'(timeout_o), 0);
        chk({tag, "_illegal"}, 32'(illegal_o), 0);
        chk({tag, "_valid"}, 32'(err_valid_o), 0);
        chk({tag, "_ch"}, 32'(err_ch_o), 0);
        chk({tag, "_code"}, 32'(err_code_o), 0);
        chk({tag, "_cnt"}, 32'(err_cnt_o), 0);
    endtask

    // Report scoreboard: every presented report must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && err_valid_o) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_report observed ch=%0d code=%0d expected=none", err_ch_o, err_code_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({err_ch_o, err_code_o} === e) else begin
                    errors++;
                    $error("FAIL report observed ch=%0d code=%0d expected ch=%0d code=%0d",
                           err_ch_o, err_code_o, e.ch, e.code);
                end
            end
        end else if (rst_n) begin
            checks++;
            assert ({err_ch_o, err_code_o} === 4'b0) else begin
                errors++;
                $error("FAIL idle_report_fields observed=%0h expected=0", {err_ch_o, err_code_o});
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        enable_i = 1'b0;
        clear_i  = 1'b0;
        for (int i = 0; i < 4; i++) st[i] = 4'd0;
        tick();
        tick();
        chk_all_zero("reset");

        rst_n    = 1'b1;
        enable_i = 1'b1;
        tick();
        tick();

        foreach (seq[i]) begin
            st[0] = 4'(seq[i]);
            repeat (3) tick();
        end
        chk("legal_cycle_flags", 32'({timeout_o, illegal_o}), 0);
        chk("legal_cycle_cnt", 32'(err_cnt_o), 0);

        st[1] = 4'd1;
        tick();
        st[1] = 4'd3;
        exp_q.push_back({2'd1, ERR_ILLEGAL});
        tick();
        chk("ill1_flag", 32'(illegal_o), 32'h2);
        chk("ill1_cnt", 32'(err_cnt_o), 1);
        tick();
        chk("ill1_valid", 32'(err_valid_o), 1);
        chk("ill1_ch", 32'(err_ch_o), 1);
        st[1] = 4'd0;
        tick();

        st[2] = 4'd1;
        tick();
        st[2] = 4'd2;
        repeat (16) tick();
        chk("to2_before", 32'(timeout_o), 0);
        exp_q.push_back({2'd2, ERR_TIMEOUT});
        tick();
        chk("to2_flag", 32'(timeout_o), 32'h4);
        chk("to2_cnt", 32'(err_cnt_o), 2);
        repeat (5) tick();
        st[2] = 4'd3;
        tick();
        st[2] = 4'd0;
        repeat (100) tick();
        chk("idle_dwell_cnt", 32'(err_cnt_o), 2);
        chk("idle_dwell_flag", 32'(timeout_o), 32'h4);

        st[0] = 4'd2;
        st[3] = 4'd3;
        exp_q.push_back({2'd0, ERR_ILLEGAL});
        exp_q.push_back({2'd3, ERR_ILLEGAL});
        tick();
        chk("dual_flags", 32'(illegal_o), 32'hB);
        chk("dual_cnt", 32'(err_cnt_o), 4);
        tick();
        chk("dual_first_ch", 32'(err_ch_o), 0);
        tick();
        chk("dual_second_ch", 32'(err_ch_o), 3);
        st[0] = 4'd3;
        st[3] = 4'd0;
        tick();
        st[0] = 4'd0;
        tick();
        tick();

        st[1] = 4'd1;
        tick();
        st[1]   = 4'd3;
        clear_i = 1'b1;
        exp_q.push_back({2'd1, ERR_ILLEGAL});
        tick();
        clear_i = 1'b0;
        chk("clear_illegal", 32'(illegal_o), 32'h2);
        chk("clear_timeout", 32'(timeout_o), 0);
        chk("clear_cnt", 32'(err_cnt_o), 1);
        tick();
        chk("clear_report_valid", 32'(err_valid_o), 1);
        st[1] = 4'd0;
        tick();

        st[1] = 4'd1;
        tick();
        st[1] = 4'd3;
        tick();
        chk("pre_reset_cnt", 32'(err_cnt_o), 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk_all_zero("post_reset");

        enable_i = 1'b0;
        tick();
        st[3] = 4'd3;
        tick();
        enable_i = 1'b1;
        tick();
        st[3] = 4'd1;
        tick();
        repeat (3) tick();
        chk("rearm_illegal", 32'(illegal_o), 0);
        chk("rearm_cnt", 32'(err_cnt_o), 0);
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
